// File: rtl/branch_cond_unit.sv
// branch_cond_unit
//   Holds the architectural {z,c,s,v} flag register fed by the ALU adder,
//   resolves conditional branches against it (with same-cycle forwarding of
//   freshly produced flags) and hands the resolved next-PC to fetch through
//   a valid/ready handshake. Carry follows the subtract convention
//   (c=1 means no borrow, a >= b unsigned).
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   flag_we, z/c/s/v_in   ALU flags valid this cycle (latched and forwarded)
//   flag_busy             a flag writer is still in flight; blocks accepts
//   br_valid/br_ready     branch request handshake (br_ready combinational)
//   br_cond               4-bit condition code
//   br_target, br_fall    taken target / fall-through PC
//   res_valid/res_ack     resolved-result handshake toward fetch
//   res_taken, res_pc     registered resolution
//   flush                 squash the pending result, block accepts
//   flags                 flag register {z,c,s,v}
//   taken_cnt             saturating count of taken branches
module branch_cond_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flag_we,
    input  logic             z_in,
    input  logic             c_in,
    input  logic             s_in,
    input  logic             v_in,
    input  logic             flag_busy,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [3:0]       br_cond,
    input  logic [WIDTH-1:0] br_target,
    input  logic [WIDTH-1:0] br_fall,
    output logic             res_valid,
    input  logic             res_ack,
    output logic             res_taken,
    output logic [WIDTH-1:0] res_pc,
    input  logic             flush,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           stateQ;
    logic [3:0]       flagReg;
    logic [3:0]       effFlags;
    logic             condTrue;
    logic             accept;
    logic             resTakenQ;
    logic [WIDTH-1:0] resPcQ;
    logic [CNT_W-1:0] takenCntQ;

    // Flags produced this very cycle override the stored copy.
    always_comb begin
        effFlags = flagReg;
        if (flag_we) begin
            effFlags = {z_in, c_in, s_in, v_in};
        end
    end

    always_comb begin
        logic fz, fc, fs, fv;
        fz = effFlags[3];
        fc = effFlags[2];
        fs = effFlags[1];
        fv = effFlags[0];
        condTrue = 1'b0;
        unique case (br_cond)
            4'd0:  condTrue = fz;
            4'd1:  condTrue = !fz;
            4'd2:  condTrue = fc;
            4'd3:  condTrue = !fc;
            4'd4:  condTrue = fs;
            4'd5:  condTrue = !fs;
            4'd6:  condTrue = fv;
            4'd7:  condTrue = !fv;
            4'd8:  condTrue = fc & !fz;
            4'd9:  condTrue = !fc | fz;
            4'd10: condTrue = (fs == fv);
            4'd11: condTrue = (fs != fv);
            4'd12: condTrue = !fz & (fs == fv);
            4'd13: condTrue = fz | (fs != fv);
            4'd14: condTrue = 1'b1;
            4'd15: condTrue = 1'b0;
            default: condTrue = 1'b0;
        endcase
    end

    // An acknowledged HOLD frees the output slot in the same cycle, which is
    // what allows one branch per cycle under continuous res_ack.
    assign br_ready = !flag_busy & ((stateQ == IDLE) | res_ack) & !flush;
    assign accept   = br_valid & br_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ    <= IDLE;
            flagReg   <= '0;
            resTakenQ <= 1'b0;
            resPcQ    <= '0;
            takenCntQ <= '0;
        end else begin
            if (flag_we) begin
                flagReg <= {z_in, c_in, s_in, v_in};
            end
            if (flush) begin
                stateQ <= IDLE;
            end else if (accept) begin
                stateQ    <= HOLD;
                resTakenQ <= condTrue;
                resPcQ    <= condTrue ? br_target : br_fall;
                if (condTrue && (takenCntQ != '1)) begin
                    takenCntQ <= takenCntQ + CNT_W'(1);
                end
            end else if ((stateQ == HOLD) && res_ack) begin
                stateQ <= IDLE;
            end
        end
    end

    assign res_valid = (stateQ == HOLD);
    assign res_taken = resTakenQ;
    assign res_pc    = resPcQ;
    assign flags     = flagReg;
    assign taken_cnt = takenCntQ;

endmodule
